// File: rtl/riscv_mpsoc_pkg.sv
// Shared write-back types for the register-file write arbiter.
package riscv_mpsoc_pkg;

  localparam int RV_XLEN    = 64;
  localparam int RV_AR_BITS = 5;

  // Widest entry the arbiter selects between; narrower builds zero-extend into it.
  typedef struct packed {
    logic [RV_AR_BITS-1:0] dst;
    logic [RV_XLEN-1:0]    dstv;
  } wb_entry_t;

  // x0 is hardwired to zero, so it never produces a register-file write.
  function automatic logic wb_writes(input logic [RV_AR_BITS-1:0] dst);
    return dst != '0;
  endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Load-result buffer: power-of-two circular FIFO with a flat view of all entries
// and their valid bits, so the parent can pick the head and scan for hazards.
module riscv_wb_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [DEPTH*W-1:0] ent_data,
  output logic [DEPTH-1:0]   ent_vld
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full     = cnt_q == (PW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_ptr   = rd_ptr_q;
  assign ent_data = mem_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign ent_vld[i] = {1'b0, off} < cnt_q;
  end

endmodule

// File: rtl/riscv_wb_arb.sv
// Register-file write-back arbiter: buffered load results win over execute results.
// Define RISCV_WB_HAZARD_EN to add the chk_src1/chk_src2/chk_hit hazard-check port.
module riscv_wb_arb
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int AR_BITS    = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [AR_BITS-1:0] ex_dst,
  input  logic [XLEN-1:0]    ex_dstv,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [AR_BITS-1:0] mem_dst,
  input  logic [XLEN-1:0]    mem_dstv,
  input  logic               du_stall,
  output logic               rf_we,
  output logic [AR_BITS-1:0] rf_dst,
  output logic [XLEN-1:0]    rf_dstv,
  output logic               wb_busy
`ifdef RISCV_WB_HAZARD_EN
  ,
  input  logic [AR_BITS-1:0] chk_src1,
  input  logic [AR_BITS-1:0] chk_src2,
  output logic               chk_hit
`endif
);

  localparam int EW = AR_BITS + XLEN;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PW-1:0]                  fifo_rd_ptr;
  logic [FIFO_DEPTH*EW-1:0]       ent_data;
  logic [FIFO_DEPTH-1:0]          ent_vld;
  logic [FIFO_DEPTH-1:0][EW-1:0]  ent_arr;
  logic [EW-1:0]                  head;
  wb_entry_t                      sel;
  logic                           sel_vld;
  logic                           rf_we_d, rf_we_q;
  logic [AR_BITS-1:0]             rf_dst_d, rf_dst_q;
  logic [XLEN-1:0]                rf_dstv_d, rf_dstv_q;

  // Acceptance looks only at registered occupancy, never at a same-cycle pop.
  assign mem_ready = !rst && !fifo_full;
  assign ex_ready  = !rst && !du_stall && fifo_empty;
  assign fifo_push = mem_valid && mem_ready;
  assign fifo_pop  = !rst && !du_stall && !fifo_empty;

  assign ent_arr = ent_data;
  assign head    = ent_arr[fifo_rd_ptr];
  assign wb_busy = |ent_vld;

  riscv_wb_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({mem_dst, mem_dstv}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_ptr    (fifo_rd_ptr),
    .ent_data  (ent_data),
    .ent_vld   (ent_vld)
  );

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (fifo_pop) begin
      sel_vld  = 1'b1;
      sel.dst  = RV_AR_BITS'(head[EW-1:XLEN]);
      sel.dstv = RV_XLEN'(head[XLEN-1:0]);
    end else if (ex_valid && ex_ready) begin
      sel_vld  = 1'b1;
      sel.dst  = RV_AR_BITS'(ex_dst);
      sel.dstv = RV_XLEN'(ex_dstv);
    end
    rf_we_d   = sel_vld && wb_writes(sel.dst);
    rf_dst_d  = sel_vld ? AR_BITS'(sel.dst) : rf_dst_q;
    rf_dstv_d = sel_vld ? XLEN'(sel.dstv)   : rf_dstv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_dst_q  <= '0;
      rf_dstv_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_dst_q  <= rf_dst_d;
      rf_dstv_q <= rf_dstv_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dst  = rf_dst_q;
  assign rf_dstv = rf_dstv_q;

`ifdef RISCV_WB_HAZARD_EN
  // A source hits if a pending load or the write currently on the port targets it.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && chk_src1 != '0 && ent_arr[i][EW-1:XLEN] == chk_src1) chk_hit = 1'b1;
      if (ent_vld[i] && chk_src2 != '0 && ent_arr[i][EW-1:XLEN] == chk_src2) chk_hit = 1'b1;
    end
    if (rf_we_q && chk_src1 != '0 && rf_dst_q == chk_src1) chk_hit = 1'b1;
    if (rf_we_q && chk_src2 != '0 && rf_dst_q == chk_src2) chk_hit = 1'b1;
  end
`endif

endmodule

// File: doc/riscv_wb_arb.md
RISCV_WB_ARB -- requirements
Module: riscv_wb_arb

Interface
REQ-001 Parameter XLEN, default 64, integer register width.
REQ-002 Parameter AR_BITS, default 5, register address width.
REQ-003 Parameter FIFO_DEPTH, default 2, load-result buffer entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ex_valid  input  1  execute result offered.
REQ-007 ex_ready  output  1  execute result accepted this cycle.
REQ-008 ex_dst  input  AR_BITS  execute destination register.
REQ-009 ex_dstv  input  XLEN  execute result value.
REQ-010 mem_valid  input  1  load result offered.
REQ-011 mem_ready  output  1  load result accepted this cycle.
REQ-012 mem_dst  input  AR_BITS  load destination register.
REQ-013 mem_dstv  input  XLEN  load result value.
REQ-014 du_stall  input  1  debug-unit stall; freezes register-file writes.
REQ-015 rf_we  output  1  register-file write enable, registered.
REQ-016 rf_dst  output  AR_BITS  register-file write address, registered.
REQ-017 rf_dstv  output  XLEN  register-file write data, registered.
REQ-018 wb_busy  output  1  high while any load result is buffered.

Function
REQ-019 A transfer on either input SHALL occur only in a cycle where valid and ready are both high.
REQ-020 Accepted load results SHALL be pushed into a FIFO of FIFO_DEPTH entries in arrival order.
REQ-021 mem_ready SHALL equal "FIFO not full", independent of du_stall and of a same-cycle pop.
REQ-022 When du_stall is low and the FIFO is non-empty, the head SHALL be popped and written out; ex_ready SHALL be 0 that cycle (loads take priority).
REQ-023 When du_stall is low and the FIFO is empty, ex_ready SHALL be 1 and an accepted execute result SHALL be written out.
REQ-024 A write-out SHALL appear on rf_we/rf_dst/rf_dstv in the cycle after selection (execute latency 1 cycle; load latency min 2 cycles).
REQ-025 A selected entry with destination 0 SHALL be consumed normally but rf_we SHALL stay 0 for it.
REQ-026 rf_we SHALL be 0 in any cycle following one with no write-out; rf_dst/rf_dstv hold their last values.
REQ-027 While du_stall is high: no pop, ex_ready=0, rf_we=0 next cycle; loads SHALL still be pushed until full.
REQ-028 Simultaneous push into an empty FIFO and execute acceptance SHALL write the execute result first, then the load.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 wb_busy SHALL be the registered-state "FIFO non-empty" flag.

Reset
REQ-031 rst high SHALL empty the FIFO, zero the pointers, and clear rf_we and wb_busy on the next edge; rf_dst and rf_dstv SHALL reset to 0.
REQ-032 During rst, ex_ready and mem_ready SHALL be 0; in-flight entries are discarded.

Configuration
REQ-033 With RISCV_WB_HAZARD_EN defined, the block SHALL add inputs chk_src1, chk_src2 (AR_BITS each) and output chk_hit (1).
REQ-034 chk_hit SHALL be combinational: 1 when a nonzero chk_src matches any valid FIFO entry destination, or rf_dst while rf_we is 1.
REQ-035 Without RISCV_WB_HAZARD_EN, these three ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-036 The write-back entry struct (dst, dstv) SHALL be a typedef in riscv_mpsoc_pkg.
REQ-037 The FIFO SHALL be a sub-module riscv_wb_fifo with push/pop/full/empty and a flat entry-view output for hazard checking.

Verification
REQ-038 Reset, then ex_valid=1, ex_dst=3, ex_dstv=0x55 -> next cycle rf_we=1, rf_dst=3, rf_dstv=0x55.
REQ-039 Same cycle: mem (dst=5, 0xAA) and ex (dst=6, 0xBB) -> rf writes 6/0xBB, then 5/0xAA; wb_busy high for one cycle.
REQ-040 du_stall=1, three loads offered -> two accepted, mem_ready=0 on third, rf_we=0; release stall -> writes in order.
REQ-041 ex_dst=0, ex_dstv=0xFF -> ex_ready=1, rf_we stays 0.
REQ-042 FIFO holding one entry, rst pulsed -> wb_busy=0, rf_we=0, entry never written.
REQ-043 (RISCV_WB_HAZARD_EN) buffered load dst=7, chk_src1=7 -> chk_hit=1; chk_src1=0 with rf_dst=0 -> chk_hit=0.
